// File: rtl/aes128_round_sequencer.sv
// aes128_round_sequencer: iterative AES-128 encryptor, one round per cycle, on-the-fly key expansion.
// Ports: clk/rst_n, in_valid/in_ready/plaintext/key in, out_valid/out_ready/ciphertext out, busy, round_idx.
module aes128_round_sequencer #(
  parameter int NR          = 10,
  parameter int EARLY_READY = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx
);

  if (NR != 10) begin : g_nr_illegal
    $error("aes128_round_sequencer: NR must be 10");
  end

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam bit         EARLY = (EARLY_READY != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t       fsm;
  logic         in_ready_r;
  logic [127:0] state_r;
  logic [127:0] rk_r;
  logic [127:0] rk_next;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] round_out;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] =
          sbox(v[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = v[127-32*c -: 32];
      o[127-32*c -: 32] = {
        xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
        xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)
      };
    end
    return o;
  endfunction

  function automatic logic [127:0] expand(
    input logic [127:0] rk,
    input logic [7:0]   rc
  );
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = rk;
    t = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]),
         sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  always_comb begin
    rk_next   = expand(rk_r, rcon(round_idx));
    sr_out    = sub_shift(state_r);
    mc_out    = (round_idx == NR_L) ? sr_out : mix_cols(sr_out);
    round_out = mc_out ^ rk_next;
  end

  // Drain-cycle accept path only exists in the EARLY variant.
  assign in_ready = in_ready_r |
                    (EARLY && fsm == S_DONE && out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      in_ready_r <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      round_idx  <= 4'd0;
      ciphertext <= '0;
      state_r    <= '0;
      rk_r       <= '0;
    end else begin
      unique case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            state_r    <= plaintext ^ key;
            rk_r       <= key;
            round_idx  <= 4'd1;
            in_ready_r <= 1'b0;
            busy       <= 1'b1;
            fsm        <= S_RUN;
          end
        end
        S_RUN: begin
          state_r <= round_out;
          rk_r    <= rk_next;
          if (round_idx == NR_L) begin
            ciphertext <= round_out;
            out_valid  <= 1'b1;
            busy       <= 1'b0;
            fsm        <= S_DONE;
          end else begin
            round_idx <= round_idx + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (EARLY && in_valid) begin
              state_r   <= plaintext ^ key;
              rk_r      <= key;
              round_idx <= 4'd1;
              busy      <= 1'b1;
              fsm       <= S_RUN;
            end else begin
              round_idx  <= 4'd0;
              in_ready_r <= 1'b1;
              fsm        <= S_IDLE;
            end
          end
        end
        default: begin
          fsm        <= S_IDLE;
          in_ready_r <= 1'b1;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          round_idx  <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// tb_aes128_round_sequencer: checks both EARLY_READY variants against a byte-level AES model.
// Ports: none; drives two DUT instances (index 0: EARLY_READY=0, index 1: EARLY_READY=1).
module tb_aes128_round_sequencer;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [1:0]   iv;
  logic [1:0]   ordy;
  logic [127:0] pt [2];
  logic [127:0] ky [2];
  logic         ir0, ir1, ov0, ov1, bz0, bz1;
  logic [127:0] ct0, ct1;
  logic [3:0]   ri0, ri1;
  logic [1:0]   ir, ov, bz;
  logic [127:0] ct [2];
  logic [3:0]   ri [2];

  assign ir = {ir1, ir0};
  assign ov = {ov1, ov0};
  assign bz = {bz1, bz0};
  assign ct[0] = ct0;
  assign ct[1] = ct1;
  assign ri[0] = ri0;
  assign ri[1] = ri1;

  aes128_round_sequencer #(.NR(10), .EARLY_READY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir0),
    .plaintext(pt[0]), .key(ky[0]),
    .out_valid(ov0), .out_ready(ordy[0]),
    .ciphertext(ct0), .busy(bz0), .round_idx(ri0)
  );

  aes128_round_sequencer #(.NR(10), .EARLY_READY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir1),
    .plaintext(pt[1]), .key(ky[1]),
    .out_valid(ov1), .out_ready(ordy[1]),
    .ciphertext(ct1), .busy(bz1), .round_idx(ri1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Reference AES built from the generator-walk S-box construction.
  logic [7:0] sb [256];

  function automatic logic [7:0] x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
                ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] p,
                                           input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] w [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = p[127-8*i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i + 4*(i%4)) % 16]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
          s[4*c+3] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      tmp[0] = sb[w[13]] ^ rc;
      tmp[1] = sb[w[14]];
      tmp[2] = sb[w[15]];
      tmp[3] = sb[w[12]];
      for (int i = 0; i < 4; i++) w[i] = w[i] ^ tmp[i];
      for (int i = 4; i < 16; i++) w[i] = w[i] ^ w[i-4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
      rc = x2(rc);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // Transaction model: block age counts edges since its accept edge.
  bit           pend [2];
  int           age  [2];
  logic [127:0] ect  [2];
  initial begin
    pend[0] = 0; pend[1] = 0; age[0] = 0; age[1] = 0;
  end

  always @(negedge clk) begin
    bit         e_ir, e_ov, e_bz;
    logic [3:0] e_ri;
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        e_ov = pend[d] && age[d] >= 11;
        e_bz = pend[d] && age[d] <= 10;
        e_ri = !pend[d] ? 4'd0 : (age[d] > 10 ? 4'd10 : 4'(age[d]));
        e_ir = !pend[d] || (d == 1 && e_ov && ordy[d]);
        chk($sformatf("in_ready[%0d]", d), 128'(ir[d]), 128'(e_ir));
        chk($sformatf("out_valid[%0d]", d), 128'(ov[d]), 128'(e_ov));
        chk($sformatf("busy[%0d]", d), 128'(bz[d]), 128'(e_bz));
        chk($sformatf("round_idx[%0d]", d), 128'(ri[d]), 128'(e_ri));
        if (e_ov) chk($sformatf("ciphertext[%0d]", d), ct[d], ect[d]);
        if (!rst_n) begin
          pend[d] = 0;
        end else if (iv[d] && e_ir) begin
          pend[d] = 1;
          age[d]  = 1;
          ect[d]  = aes_enc(pt[d], ky[d]);
        end else if (e_ov && ordy[d]) begin
          pend[d] = 0;
        end else if (pend[d] && age[d] < 11) begin
          age[d]++;
        end
      end
    end
  end

  typedef struct {
    int           d;
    int           c;
    logic [127:0] v;
  } ev_t;
  ev_t  rise_q [$];
  logic [1:0] ovp = 2'b00;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (armed && ov[d] && !ovp[d]) rise_q.push_back('{d, cyc, ct[d]});
    end
    ovp = ov;
  end

  task automatic send(input int d, input logic [127:0] p,
                      input logic [127:0] k, output int acc);
    pt[d] = p;
    ky[d] = k;
    iv[d] = 1'b1;
    acc = -1;
    for (int n = 0; n < 200 && acc < 0; n++) begin
      @(negedge clk);
      if (ir[d]) acc = cyc;
      @(posedge clk);
      #1;
    end
    iv[d] = 1'b0;
    if (acc < 0) timeout("send");
  endtask

  task automatic wait_ov(input int d, output int c);
    c = -1;
    for (int n = 0; n < 100 && c < 0; n++) begin
      @(negedge clk);
      if (ov[d]) c = cyc;
    end
    if (c < 0) timeout("wait_out_valid");
  endtask

  int a, b, c;
  ev_t e1, e2;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    build_sbox();
    rst_n = 1'b0;
    iv = 2'b00;
    ordy = 2'b11;
    pt[0] = '0; pt[1] = '0; ky[0] = '0; ky[1] = '0;

    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    chk("model_vec1", aes_enc(PT1, K1), CT1);
    chk("model_vec2", aes_enc(PT2, K2), CT2);

    @(posedge clk); #1;
    armed = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ct0", ct[0], 128'h0);
    chk("reset_ct1", ct[1], 128'h0);
    chk("reset_ir0", 128'(ir[0]), 128'h1);
    chk("reset_ri0", 128'(ri[0]), 128'h0);
    @(posedge clk); #1;

    // Vector 1, latency
    send(0, PT1, K1, a);
    wait_ov(0, c);
    chk("t1_latency", 128'(c - a), 128'd11);
    chk("t1_ct", ct[0], CT1);
    @(posedge clk); #1;

    // Vector 2, round counter walk
    send(0, PT2, K2, a);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("t2_round_%0d", k), 128'(ri[0]), 128'(k));
    end
    @(negedge clk);
    chk("t2_ov", 128'(ov[0]), 128'h1);
    chk("t2_ct", ct[0], CT2);
    @(posedge clk); #1;

    // Backpressure with ignored input pulses
    ordy[0] = 1'b0;
    send(0, PT1, K1, a);
    wait_ov(0, c);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      iv[0] = 1'($urandom_range(0, 1));
      pt[0] = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("t3_ov_hold", 128'(ov[0]), 128'h1);
      chk("t3_ct_hold", ct[0], CT1);
      chk("t3_ir_low", 128'(ir[0]), 128'h0);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset in the middle of a block
    send(0, PT1, K1, a);
    repeat (4) @(posedge clk);
    #1;
    chk("t5_at_round5", 128'(ri[0]), 128'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("t5_ov_low", 128'(ov[0]), 128'h0);
      chk("t5_ir_high", 128'(ir[0]), 128'h1);
      chk("t5_ri_zero", 128'(ri[0]), 128'h0);
    end
    @(posedge clk); #1;
    send(0, PT1, K1, a);
    wait_ov(0, c);
    chk("t5_ct_after", ct[0], CT1);
    @(posedge clk); #1;

    // Back-to-back accept on the drain cycle (EARLY variant)
    rise_q.delete();
    send(1, PT1, K1, a);
    send(1, PT2, K2, b);
    chk("t4_accept_gap", 128'(b - a), 128'd11);
    wait_ov(1, c);
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (rise_q.size() < 2) begin
      timeout("t4_two_outputs");
    end else begin
      e1 = rise_q[0];
      e2 = rise_q[1];
      chk("t4_first_ct", e1.v, CT1);
      chk("t4_second_ct", e2.v, CT2);
      chk("t4_spacing", 128'(e2.c - e1.c), 128'd11);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
